// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receiver.
// ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int C_DATA_BITS_DEF = 8;

  // 16x oversampling: start bit checked at mid-bit, later bits one full period apart
  localparam logic [3:0] TICK_MID = 4'd7;
  localparam logic [3:0] TICK_END = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY = 3'd4
`endif
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high level so reset release never looks like a start edge.
module uart_sync2 (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with single-entry holding register.
// Optional parity check compiled in with macro UART_RX_PARITY_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a synchronized 1->0 edge
// ST_START  | confirming start bit at mid-bit (glitch reject)
// ST_DATA   | sampling C_DATA_BITS data bits, LSB first
// ST_PARITY | sampling the parity bit (parity builds only)
// ST_STOP   | sampling stop bit, then load/discard the character
module uart_rx
  import uart_pkg::*;
#(
  parameter int C_DATA_BITS  = C_DATA_BITS_DEF,
  parameter int C_ODD_PARITY = 0
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   EN_16x_Baud,
  input  logic                   RX,
  output logic [C_DATA_BITS-1:0] RX_Data,
  output logic                   RX_Data_Present,
  input  logic                   Read_RX_Data,
  output logic                   Frame_Error,
  output logic                   Overrun_Error,
  output logic                   Parity_Error
);

  localparam logic [3:0] LAST_BIT = 4'(C_DATA_BITS - 1);

  uart_state_e state, state_nxt;

  logic                   rx_s;
  logic                   rx_q;
  logic [3:0]             tick;
  logic [3:0]             bit_cnt;
  logic [C_DATA_BITS-1:0] shreg;
  logic                   tick_mid;
  logic                   tick_end;
  logic                   tick_clr;
  logic                   data_smp;
  logic                   stop_smp;
`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (C_ODD_PARITY != 0);
  logic par_smp;
  logic par_bad;
`endif

  uart_sync2 u_sync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .d       (RX),
    .q       (rx_s)
  );

  assign tick_mid = EN_16x_Baud && (tick == TICK_MID);
  assign tick_end = EN_16x_Baud && (tick == TICK_END);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      rx_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      rx_q  <= rx_s;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_clr  = 1'b0;
    data_smp  = 1'b0;
    stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (rx_q && !rx_s) begin
          state_nxt = ST_START;
          tick_clr  = 1'b1;
        end
      end
      ST_START: begin
        if (tick_mid) begin
          tick_clr  = 1'b1;
          state_nxt = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick_end) begin
          data_smp = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_end) begin
          par_smp   = 1'b1;
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // returning to IDLE at mid stop bit leaves half a bit to catch the next edge
        if (tick_end) begin
          stop_smp  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tick    <= 4'd0;
      bit_cnt <= 4'd0;
      shreg   <= '0;
    end else begin
      if (tick_clr) begin
        tick <= 4'd0;
      end else if (EN_16x_Baud) begin
        tick <= tick + 4'd1;
      end
      if (state == ST_START) begin
        bit_cnt <= 4'd0;
      end else if (data_smp) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (data_smp) begin
        shreg <= {rx_s, shreg[C_DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RX_Data         <= '0;
      RX_Data_Present <= 1'b0;
      Frame_Error     <= 1'b0;
      Overrun_Error   <= 1'b0;
    end else begin
      Frame_Error   <= 1'b0;
      Overrun_Error <= 1'b0;
      if (stop_smp) begin
        Frame_Error <= ~rx_s;
        // a read in the same cycle frees the holding register for the new character
        if (!RX_Data_Present || Read_RX_Data) begin
          RX_Data         <= shreg;
          RX_Data_Present <= 1'b1;
        end else begin
          Overrun_Error <= 1'b1;
        end
      end else if (Read_RX_Data) begin
        RX_Data_Present <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      par_bad      <= 1'b0;
      Parity_Error <= 1'b0;
    end else begin
      if (par_smp) begin
        par_bad <= ((^shreg) ^ rx_s) != ODD;
      end
      Parity_Error <= stop_smp && par_bad;
    end
  end
`else
  assign Parity_Error = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter C_DATA_BITS, default 8, meaning data bits per frame (5..8).
REQ-002 SHALL have parameter C_ODD_PARITY, default 0, meaning 1 = odd parity, 0 = even; used only when UART_RX_PARITY_EN is defined.
REQ-003 SHALL have port Clk  input  1  system clock; the block uses one clock.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port EN_16x_Baud  input  1  single-Clk pulse at 16x the baud rate.
REQ-006 SHALL have port RX  input  1  serial line, asynchronous, idle high.
REQ-007 SHALL have port RX_Data  output  C_DATA_BITS  last received character.
REQ-008 SHALL have port RX_Data_Present  output  1  high while RX_Data holds an unread character.
REQ-009 SHALL have port Read_RX_Data  input  1  single-Clk consumer acknowledge.
REQ-010 SHALL have port Frame_Error  output  1  single-Clk pulse when the stop bit is sampled low.
REQ-011 SHALL have port Overrun_Error  output  1  single-Clk pulse when a character is lost.
REQ-012 SHALL have port Parity_Error  output  1  single-Clk pulse on parity mismatch.

Function
REQ-013 SHALL pass RX through a 2-flop synchronizer before any use; both flops SHALL reset to 1.
REQ-014 SHALL run FSM states IDLE, START, DATA, PARITY, STOP; a 4-bit tick counter SHALL advance only on EN_16x_Baud.
REQ-015 In IDLE, a synchronized 1->0 transition SHALL enter START and clear the tick counter.
REQ-016 In START, at tick 7: RX=0 SHALL enter DATA with the counter cleared; RX=1 SHALL return to IDLE with no output activity (glitch reject).
REQ-017 DATA SHALL sample at tick 15 of each bit period, LSB first, for exactly C_DATA_BITS bits, then enter PARITY (macro defined) or STOP.
REQ-018 PARITY SHALL sample one bit at tick 15 and compare it with the XOR of the data bits, adjusted by C_ODD_PARITY.
REQ-019 STOP SHALL sample at tick 15 and then return to IDLE in the same Clk cycle, leaving a half-bit for resynchronization.
REQ-020 At the stop sample, with RX_Data_Present=0 or Read_RX_Data=1, RX_Data SHALL load and RX_Data_Present SHALL be 1 on the next Clk.
REQ-021 At the stop sample, with RX_Data_Present=1 and Read_RX_Data=0, the new character SHALL be discarded, RX_Data SHALL hold, and Overrun_Error SHALL pulse.
REQ-022 A stop bit sampled low SHALL pulse Frame_Error; the character SHALL still be loaded per REQ-020/021.
REQ-023 Parity_Error SHALL pulse in the same cycle as the load or discard of the offending character.
REQ-024 Read_RX_Data with no load in the same cycle SHALL clear RX_Data_Present on the next Clk; Read_RX_Data while RX_Data_Present=0 SHALL be ignored.
REQ-025 Latency from the stop-bit sample tick to RX_Data_Present high SHALL be 1 Clk.

Reset
REQ-026 Reset_n low SHALL asynchronously force IDLE, counters 0, RX_Data 0, and RX_Data_Present, Frame_Error, Overrun_Error and Parity_Error all 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, the first 1->0 edge SHALL start a new frame.

Configuration
REQ-028 When macro UART_RX_PARITY_EN is defined, the PARITY state and parity checking SHALL be compiled in.
REQ-029 When UART_RX_PARITY_EN is undefined, the PARITY state SHALL be absent and Parity_Error SHALL be tied to 0.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state encoding, the tick-count constants (7, 15) and the C_DATA_BITS default.
REQ-031 The 2-flop synchronizer SHALL be sub-module uart_sync2; all other logic SHALL be in uart_rx.

Verification
REQ-032 The bench SHALL drive EN_16x_Baud every 4 Clk, send 0xA5 (8N1), and require RX_Data=0xA5 with RX_Data_Present=1 one Clk after the stop sample and no error pulses.
REQ-033 The bench SHALL drive a 3-tick low glitch on RX and require return to IDLE, no RX_Data_Present, and a following 0x3C received correctly.
REQ-034 The bench SHALL send 0x11 then 0x22 without Read_RX_Data and require one Overrun_Error pulse with RX_Data=0x11 retained.
REQ-035 The bench SHALL send 0x55 with the stop bit forced low and require one Frame_Error pulse with RX_Data=0x55.
REQ-036 With UART_RX_PARITY_EN and C_ODD_PARITY=0, the bench SHALL send 0x07 with parity bit 0 and require one Parity_Error pulse; with parity bit 1 it SHALL require no pulse.
REQ-037 The bench SHALL assert Reset_n low during data bit 3 and require all outputs 0 immediately, then a correct reception of 0x81 after release.
